// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready for operations, out_valid/out_ready for results.
// Ports: in_valid, in_ready, funct3, a, b, flush (request side); out_valid, out_ready, result (response side).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  // pipeline side
  modport master (
    output in_valid, funct3, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  // unit side
  modport slave (
    input  in_valid, funct3, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide (radix-2 shift-add, restoring divide).
// Latency: XLEN+1 cycles iterative, 1 cycle for divide-by-zero / signed overflow (and multiply with MULDIV_FAST_MUL_EN).
// Backpressure: result held in DONE until out_ready; in_ready low until the cycle after handoff; flush aborts.
// Ports: clk, reset (sync, active-high), bus (muldiv_unit_if.slave).
// Optional: `define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier; divide unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state;
  logic [1:0]        op;        // funct3[1:0] is enough once mul/div is encoded in the state
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p;         // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   d;         // mul: multiplicand magnitude; div: divisor magnitude
  logic              neg_q;     // negate product / quotient at the end
  logic              neg_r;     // negate remainder at the end
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;

  // incoming op decode
  logic            is_mul, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, accept;

  always_comb begin
    is_mul   = ~bus.funct3[2];
    a_sgn    = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) | (bus.funct3[2] & ~bus.funct3[0]);
    b_sgn    = (bus.funct3 == 3'b001) | (bus.funct3[2] & ~bus.funct3[0]);
    a_neg    = a_sgn & bus.a[XLEN-1];
    b_neg    = b_sgn & bus.b[XLEN-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    div_zero = bus.funct3[2] & (bus.b == '0);
    div_ovf  = bus.funct3[2] & ~bus.funct3[0] &
               (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
    accept   = bus.in_valid & (state == S_IDLE) & ~bus.flush;
  end

`ifdef MULDIV_FAST_MUL_EN
  // one extra bit per operand carries the signedness, so a single signed
  // multiply covers MULH, MULHSU and MULHU; 2*XLEN bits of it are exact
  logic [XLEN:0]     ea, eb;
  logic [2*XLEN-1:0] fprod;
  assign ea    = {a_sgn & bus.a[XLEN-1], bus.a};
  assign eb    = {b_sgn & bus.b[XLEN-1], bus.b};
  assign fprod = $signed(ea) * $signed(eb);
`endif

  // one iteration step plus the sign fix-up applied on the final step
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_sub, quo_f, rem_f, fin;
  logic [2*XLEN-1:0] p_nxt, prod_f;

  always_comb begin
    mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? d : {XLEN{1'b0}})};
    rem_sh  = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    ge      = rem_sh >= {1'b0, d};
    // when ge holds the true difference is below d, so XLEN bits suffice
    rem_sub = rem_sh[XLEN-1:0] - d;
    p_nxt   = p;
    if (state == S_MUL)
      p_nxt = {mul_sum, p[XLEN-1:1]};
    else if (state == S_DIV)
      p_nxt = {(ge ? rem_sub : rem_sh[XLEN-1:0]), p[XLEN-2:0], ge};
    prod_f = neg_q ? -p_nxt : p_nxt;
    quo_f  = neg_q ? -p_nxt[XLEN-1:0] : p_nxt[XLEN-1:0];
    rem_f  = neg_r ? -p_nxt[2*XLEN-1:XLEN] : p_nxt[2*XLEN-1:XLEN];
    if (state == S_MUL)
      fin = (op == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    else
      fin = op[1] ? rem_f : quo_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (bus.flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op    <= bus.funct3[1:0];
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero) begin
              result_q    <= bus.funct3[1] ? bus.a : '1;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else if (div_ovf) begin
              result_q    <= bus.funct3[1] ? '0 : bus.a;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (is_mul) begin
              result_q    <= (bus.funct3 == 3'b000) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
              out_valid_q <= 1'b1;
              state       <= S_DONE;
`else
            end else if (is_mul) begin
              d     <= a_mag;
              p     <= {{XLEN{1'b0}}, b_mag};
              state <= S_MUL;
`endif
            end else begin
              d     <= b_mag;
              p     <= {{XLEN{1'b0}}, a_mag};
              state <= S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          p   <= p_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            result_q    <= fin;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32: directed vectors, latency and handoff checks.
// Latency expectations follow MULDIV_FAST_MUL_EN when it is defined for the build.
// Backpressure, flush and mid-operation reset are exercised explicitly.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int DL   = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = XLEN + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          t;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   prev_ov = 1'b0;
  bit   prev_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // monitor: latency on the rising edge of out_valid, value on handoff
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("ov_one_cycle", bus.out_valid, 0);
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid actual=out_valid=1 required=no pending op");
        end else begin
          check({sb[0].name, "_lat"}, cyc - sb[0].t, sb[0].lat);
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
      if (prev_hs && sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, bus.result, e.res);
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input int lat, input string nm, input bit track);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept actual=in_ready=0 required=1", nm);
      return;
    end
    bus.funct3   = f;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    if (track) sb.push_back('{res: r, t: cyc, lat: lat, name: nm});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input int lat, input string nm);
    issue(f, x, y, r, lat, nm, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);

    // multiplies
    run(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML, "mul");
    run(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, ML, "mulh");
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, "mulhu");
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, "mulhsu");
    run(3'b001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, ML, "mulh_neg");
    // iterative divides
    run(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DL, "div");
    run(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DL, "rem");
    run(3'b101, 32'd100,      32'd7,        32'd14,       DL, "divu");
    run(3'b111, 32'd100,      32'd7,        32'd2,        DL, "remu");
    run(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DL, "div_negb");
    // early-out cases
    run(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
    run(3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu_by0");
    run(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0");
    run(3'b110, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 1,  "rem_by0");
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");

    // backpressure: result held, unit busy until handoff
    bus.out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 32'd14, DL, "bp_divu", 1'b1);
    for (int n = 0; n < 100 && !bus.out_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_result", bus.result, 32'd14);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", bus.in_ready, 1);
    drain();

    // flush in an idle cycle blocks acceptance
    bus.funct3   = 3'b101;
    bus.a        = 32'd5;
    bus.b        = 32'd0;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_in_ready", bus.in_ready, 1);
    repeat (3) @(posedge clk);
    #1;

    // flush at T+10 of a DIVU
    issue(3'b101, 32'd100, 32'd7, 32'd0, DL, "flushed_divu", 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_out_valid", bus.out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    run(3'b000, 32'd3, 32'd4, 32'd12, ML, "mul_after_flush");

    // reset at T+10 of a DIVU
    issue(3'b101, 32'd100, 32'd7, 32'd0, DL, "reset_divu", 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 0);
    repeat (40) @(posedge clk);
    #1;
    run(3'b000, 32'd3, 32'd4, 32'd12, ML, "mul_after_reset");

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
